// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state type and op-classification helpers for the
// iterative RV64M multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] MDU_OP_MUL    = 4'd0;
    localparam logic [3:0] MDU_OP_MULH   = 4'd1;
    localparam logic [3:0] MDU_OP_MULHSU = 4'd2;
    localparam logic [3:0] MDU_OP_MULHU  = 4'd3;
    localparam logic [3:0] MDU_OP_DIV    = 4'd4;
    localparam logic [3:0] MDU_OP_DIVU   = 4'd5;
    localparam logic [3:0] MDU_OP_REM    = 4'd6;
    localparam logic [3:0] MDU_OP_REMU   = 4'd7;
    localparam logic [3:0] MDU_OP_MULW   = 4'd8;
    localparam logic [3:0] MDU_OP_DIVW   = 4'd9;
    localparam logic [3:0] MDU_OP_DIVUW  = 4'd10;
    localparam logic [3:0] MDU_OP_REMW   = 4'd11;
    localparam logic [3:0] MDU_OP_REMUW  = 4'd12;

    // Width of the *W operand/result field.
    localparam int MDU_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_REM, MDU_OP_REMU,
                          MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return op inside {MDU_OP_REM, MDU_OP_REMU, MDU_OP_REMW, MDU_OP_REMUW};
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op inside {MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_DIVUW,
                          MDU_OP_REMW, MDU_OP_REMUW};
    endfunction

    function automatic logic is_mulh(input logic [3:0] op);
        return op inside {MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU};
    endfunction

    // rs1 interpreted as signed
    function automatic logic is_signed(input logic [3:0] op);
        return op inside {MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_DIV, MDU_OP_REM,
                          MDU_OP_DIVW, MDU_OP_REMW};
    endfunction

    // rs2 interpreted as signed (MULHSU deliberately excluded)
    function automatic logic is_signed2(input logic [3:0] op);
        return op inside {MDU_OP_MULH, MDU_OP_DIV, MDU_OP_REM,
                          MDU_OP_DIVW, MDU_OP_REMW};
    endfunction

endpackage

// File: rtl/ex_mdu_iter_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN+1:0] rem_shift;
    logic [XLEN+1:0] trial;
    logic            q_bit;

    always_comb begin
        rem_shift = {rem_i, quo_i[XLEN-1]};
        trial     = rem_shift - {2'b00, dvsr_i};
        // No borrow out of the top bit means the divisor fits.
        q_bit     = ~trial[XLEN+1];
        rem_o     = q_bit ? trial[XLEN:0] : rem_shift[XLEN:0];
        quo_o     = {quo_i[XLEN-2:0], q_bit};
    end

endmodule

// File: rtl/ex_mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// with a same-cycle fast path for divide-by-zero and signed overflow.
module ex_mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int W_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            mdu_stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW  = $clog2(XLEN);
    localparam int WW  = MDU_WORD_W;
    localparam int WSH = XLEN - W_ITER;
    localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_W = CW'(W_ITER - 1);

    function automatic logic [XLEN-1:0] sext_w(input logic [WW-1:0] v);
        return {{(XLEN-WW){v[WW-1]}}, v};
    endfunction

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
    logic              a_neg, b_neg;
    logic              div_zero, div_ovf, fast_hit, fast_done;
    logic [XLEN-1:0]   fast_raw, fast_val;

    logic [XLEN:0]     hi_sum;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN:0]     rem_step;
    logic [XLEN-1:0]   quo_step, div_mag, div_val, final_res;
    logic [CW-1:0]     last_cnt;

    // Operand preparation and fast-path detection on the incoming op.
    always_comb begin
        if (is_word(op_i)) begin
            a_ext   = is_signed(op_i)  ? sext_w(src1_i[WW-1:0]) : {{(XLEN-WW){1'b0}}, src1_i[WW-1:0]};
            b_ext   = is_signed2(op_i) ? sext_w(src2_i[WW-1:0]) : {{(XLEN-WW){1'b0}}, src2_i[WW-1:0]};
            min_val = sext_w({1'b1, {(WW-1){1'b0}}});
        end else begin
            a_ext   = src1_i;
            b_ext   = src2_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg = is_signed(op_i)  & a_ext[XLEN-1];
        b_neg = is_signed2(op_i) & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        div_zero = (b_ext == '0);
        div_ovf  = is_signed2(op_i) && (a_ext == min_val) && (b_ext == '1);
        fast_hit = is_div(op_i) && (div_zero || div_ovf);
        if (div_zero) begin
            fast_raw = is_rem(op_i) ? a_ext : '1;
        end else begin
            fast_raw = is_rem(op_i) ? '0 : a_ext;
        end
        fast_val = is_word(op_i) ? sext_w(fast_raw[WW-1:0]) : fast_raw;
    end

    mdu_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (mcand_q),
        .rem_o  (rem_step),
        .quo_o  (quo_step)
    );

    // Multiply step plus final sign correction, evaluated on the last iteration.
    always_comb begin
        hi_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
        acc_step = {hi_sum, acc_q[XLEN-1:1]};
        prod     = neg_q ? -acc_step : acc_step;
        div_mag  = is_rem(op_q) ? rem_step[XLEN-1:0] : quo_step;
        div_val  = neg_q ? -div_mag : div_mag;
        last_cnt = is_word(op_q) ? LAST_W : LAST_D;

        if (is_div(op_q)) begin
            final_res = is_word(op_q) ? sext_w(div_val[WW-1:0]) : div_val;
        end else if (is_mulh(op_q)) begin
            final_res = prod[2*XLEN-1:XLEN];
        end else if (is_word(op_q)) begin
            // After W_ITER shifts the product sits WSH bits above bit 0.
            final_res = sext_w(acc_step[WSH +: WW]);
        end else begin
            final_res = prod[XLEN-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        neg_d       = neg_q;
        done_d      = 1'b0;
        result_d    = result_q;
        mdu_stall_o = 1'b0;
        fast_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    if (fast_hit) begin
                        fast_done = 1'b1;
                    end else begin
                        state_d     = ST_BUSY;
                        mdu_stall_o = 1'b1;
                        op_d        = op_i;
                        cnt_d       = '0;
                        neg_d       = is_rem(op_i) ? a_neg : (a_neg ^ b_neg);
                        if (is_div(op_i)) begin
                            mcand_d = b_mag;
                            rem_d   = '0;
                            // Word dividends are pre-shifted so the MSB-first loop sees them first.
                            quo_d   = is_word(op_i) ? (a_mag << WSH) : a_mag;
                        end else begin
                            mcand_d = a_mag;
                            acc_d   = {{XLEN{1'b0}}, b_mag};
                        end
                    end
                end
            end
            ST_BUSY: begin
                mdu_stall_o = 1'b1;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div(op_q)) begin
                        rem_d = rem_step;
                        quo_d = quo_step;
                    end else begin
                        acc_d = acc_step;
                    end
                    if (cnt_q == last_cnt) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        done_d   = 1'b1;
                        result_d = final_res;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MDU_OP_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done_o   = done_q | fast_done;
    assign result_o = fast_done ? fast_val : result_q;

endmodule
